// File: rtl/lock_pkg.sv
// Shared definitions for the code lock front end and decider.
//   KEY_0..KEY_9, KEY_STAR, KEY_HASH : 4-bit key codes as seen on Code_1
//   lock_state_t                     : one-hot debounce FSM state encoding
//   frame_kind_t                     : classification of one full keypad scan frame
//   key_code()                       : (row, column) position -> key code
package lock_pkg;

  localparam logic [3:0] KEY_0    = 4'b0000;
  localparam logic [3:0] KEY_1    = 4'b0001;
  localparam logic [3:0] KEY_2    = 4'b0010;
  localparam logic [3:0] KEY_3    = 4'b0011;
  localparam logic [3:0] KEY_4    = 4'b0100;
  localparam logic [3:0] KEY_5    = 4'b0101;
  localparam logic [3:0] KEY_6    = 4'b0110;
  localparam logic [3:0] KEY_7    = 4'b0111;
  localparam logic [3:0] KEY_8    = 4'b1000;
  localparam logic [3:0] KEY_9    = 4'b1001;
  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    DEBOUNCE = 4'b0010,
    PRESSED  = 4'b0100,
    RELEASE  = 4'b1000
  } lock_state_t;

  typedef enum logic [1:0] {
    FRAME_NONE  = 2'd0,
    FRAME_KEY   = 2'd1,
    FRAME_MULTI = 2'd2
  } frame_kind_t;

  // Keypad layout: r0: 1 2 3 | r1: 4 5 6 | r2: 7 8 9 | r3: * 0 #
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Key event bus from the keypad encoder to the lock decider.
//   Code_1   : code of the last accepted key, held until the next accepted key
//   Valid_1  : single-cycle strobe; Code_1 is valid in the same cycle. There is no
//              back-pressure: the consumer must take the code on the strobe cycle.
//   key_held : high from acceptance of a key until its release is debounced
interface keypad_encoder_if;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       key_held;

  modport master (output Code_1, output Valid_1, output key_held);
  modport slave  (input  Code_1, input  Valid_1, input  key_held);
endinterface

// File: rtl/keypad_encoder_scan.sv
// keypad_scan: drives the 4x3 keypad columns one at a time, synchronises the
// asynchronous rows, and classifies each full 3-column frame.
//   clk, reset_1 : clock, asynchronous active-high reset
//   row_in       : keypad rows, active-low, asynchronous to clk
//   col_out      : column drive, active-low, exactly one column low
//   frame_done   : one-cycle pulse after the last slot of column 2
//   frame_kind   : NONE / KEY / MULTI for the frame just finished
//   frame_key    : key code when frame_kind is KEY
module keypad_scan
  import lock_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_1,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic        frame_done,
  output frame_kind_t frame_kind,
  output logic [3:0]  frame_key
);

  localparam int            SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_n;     // low bits seen so far in this frame, saturating at 2
  logic [3:0]    acc_key;   // code of the single low bit, if exactly one so far

  logic       slot_last;
  logic [3:0] row_low;
  logic [2:0] n_low;
  logic [1:0] low_row;
  logic [1:0] tot_n;
  logic [3:0] tot_key;

  always_comb begin
    slot_last = (slot_cnt == SLOT_LAST);
    row_low   = ~row_sync;
    n_low     = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
    low_row   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) low_row = 2'(r);
    end
    // Only "none / exactly one / more" matters, so the running total saturates at 2.
    if ((n_low >= 3'd2) || (acc_n == 2'd2) || ((acc_n == 2'd1) && (n_low != 3'd0))) begin
      tot_n = 2'd2;
    end else begin
      tot_n = acc_n + n_low[1:0];
    end
    tot_key = acc_key;
    if ((acc_n == 2'd0) && (n_low == 3'd1)) tot_key = key_code(low_row, col_idx);
  end

  always_comb begin
    case (col_idx)
      2'd1:    col_out = 3'b101;
      2'd2:    col_out = 3'b011;
      default: col_out = 3'b110;
    endcase
  end

  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      row_meta   <= 4'b1111;
      row_sync   <= 4'b1111;
      slot_cnt   <= '0;
      col_idx    <= 2'd0;
      acc_n      <= 2'd0;
      acc_key    <= 4'd0;
      frame_done <= 1'b0;
      frame_kind <= FRAME_NONE;
      frame_key  <= 4'd0;
    end else begin
      row_meta   <= row_in;
      row_sync   <= row_meta;
      frame_done <= 1'b0;
      if (slot_last) begin
        // Rows are sampled on the last slot cycle so the synchroniser has settled
        // on the column driven since the start of the slot.
        slot_cnt <= '0;
        if (col_idx == 2'd2) begin
          col_idx    <= 2'd0;
          frame_done <= 1'b1;
          frame_kind <= (tot_n == 2'd0) ? FRAME_NONE :
                        (tot_n == 2'd1) ? FRAME_KEY  : FRAME_MULTI;
          frame_key  <= tot_key;
          acc_n      <= 2'd0;
          acc_key    <= 4'd0;
        end else begin
          col_idx <= col_idx + 2'd1;
          acc_n   <= tot_n;
          acc_key <= tot_key;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: code lock front end. Scans the keypad, debounces whole frames
// and emits one Valid_1 strobe with the key code per accepted press.
//   clk, reset_1 : clock, asynchronous active-high reset
//   row_in       : keypad rows, active-low, asynchronous
//   col_out      : keypad column drive, active-low
//   lock_if      : Code_1 / Valid_1 / key_held towards the lock decider
//   state_dbg    : current debounce FSM state
module keypad_encoder
  import lock_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic              clk,
  input  logic              reset_1,
  input  logic [3:0]        row_in,
  output logic [2:0]        col_out,
  keypad_encoder_if.master  lock_if,
  output lock_state_t       state_dbg
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam bit            SINGLE  = (DEBOUNCE_SCANS == 1);

  logic        frame_done;
  frame_kind_t frame_kind;
  logic [3:0]  frame_key;

  lock_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          held_q;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .reset_1    (reset_1),
    .row_in     (row_in),
    .col_out    (col_out),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_key  (frame_key)
  );

  // Saturating so a long stable run can never wrap back below the threshold.
  always_comb cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // The strobe is raised only on entry to PRESSED from IDLE/DEBOUNCE; returning
  // from RELEASE on a bounce re-enters PRESSED silently.
  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (frame_kind == FRAME_KEY) begin
              cand <= frame_key;
              if (SINGLE) begin
                state   <= PRESSED;
                cnt     <= '0;
                valid_q <= 1'b1;
                code_q  <= frame_key;
                held_q  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEBOUNCE: begin
            if (frame_kind == FRAME_KEY) begin
              if (frame_key == cand) begin
                if (cnt_inc == CNT_MAX) begin
                  state   <= PRESSED;
                  cnt     <= '0;
                  valid_q <= 1'b1;
                  code_q  <= cand;
                  held_q  <= 1'b1;
                end else begin
                  cnt <= cnt_inc;
                end
              end else begin
                cand <= frame_key;
                cnt  <= CNT_ONE;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            // Rollover and extra keys are ignored while a key is held.
            if (frame_kind == FRAME_NONE) begin
              if (SINGLE) begin
                state  <= IDLE;
                cnt    <= '0;
                held_q <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end
          RELEASE: begin
            if (frame_kind == FRAME_NONE) begin
              if (cnt_inc == CNT_MAX) begin
                state  <= IDLE;
                cnt    <= '0;
                held_q <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lock_if.Code_1   = code_q;
  assign lock_if.Valid_1  = valid_q;
  assign lock_if.key_held = held_q;
  assign state_dbg        = state;

endmodule
